pe_array: RTL and testbench

PE_ARRAY -- requirements
Module: pe_array

---
 rtl/pe_array.sv | 148 ++++++++++++++
 tb/tb_pe_array.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array.sv
// pe_array: 5x5 weight-stationary systolic multiply-accumulate array.
//   Each PE(i,j) holds a signed weight. It forwards its activation to the right
//   and its partial sum b_in + a_in*w downward, each after PE_LATENCY cycles.
//   The column results y0..y4 are summed into a registered acc_out.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   WorI                   1 = weight load (pipelines flush to 0), 0 = inference
//   a0_in..a4_in           row activation inputs
//   b0_in..b4_in           column partial-sum seeds, sign-extended on entry
//   weight_in              weight data
//   weight_location        row-major PE index; values 25..31 are ignored
//   y0_out..y4_out         column results (bottom-row partial sums)
//   acc_out                registered sum of y0..y4
//   aIJ_out, bIJ_out       activation / partial sum leaving PE(I,J)
//   wIJ_out                weight stored in PE(I,J)
module pe_array #(
   parameter int DATA_WIDTH = 22,
   parameter int PORT_WIDTH = 8,
   parameter int N          = 5,
   parameter int PE_LATENCY = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         WorI,
   input  logic signed [PORT_WIDTH-1:0] a0_in, a1_in, a2_in, a3_in, a4_in,
   input  logic signed [PORT_WIDTH-1:0] b0_in, b1_in, b2_in, b3_in, b4_in,
   input  logic signed [PORT_WIDTH-1:0] weight_in,
   input  logic        [4:0]            weight_location,
   output logic signed [DATA_WIDTH-1:0] y0_out, y1_out, y2_out, y3_out, y4_out,
   output logic signed [DATA_WIDTH+3:0] acc_out,
   output logic signed [PORT_WIDTH-1:0] a00_out, a01_out, a02_out, a03_out, a04_out,
                                        a10_out, a11_out, a12_out, a13_out, a14_out,
                                        a20_out, a21_out, a22_out, a23_out, a24_out,
                                        a30_out, a31_out, a32_out, a33_out, a34_out,
                                        a40_out, a41_out, a42_out, a43_out, a44_out,
   output logic signed [DATA_WIDTH-1:0] b00_out, b01_out, b02_out, b03_out, b04_out,
                                        b10_out, b11_out, b12_out, b13_out, b14_out,
                                        b20_out, b21_out, b22_out, b23_out, b24_out,
                                        b30_out, b31_out, b32_out, b33_out, b34_out,
                                        b40_out, b41_out, b42_out, b43_out, b44_out,
   output logic signed [PORT_WIDTH-1:0] w00_out, w01_out, w02_out, w03_out, w04_out,
                                        w10_out, w11_out, w12_out, w13_out, w14_out,
                                        w20_out, w21_out, w22_out, w23_out, w24_out,
                                        w30_out, w31_out, w32_out, w33_out, w34_out,
                                        w40_out, w41_out, w42_out, w43_out, w44_out
);

   localparam int PW2 = 2 * PORT_WIDTH;

   logic signed [PORT_WIDTH-1:0] w_q  [N][N];
   logic signed [PORT_WIDTH-1:0] a_q  [N][N][PE_LATENCY];
   logic signed [DATA_WIDTH-1:0] b_q  [N][N][PE_LATENCY];

   logic signed [PORT_WIDTH-1:0] a_edge [N];
   logic signed [DATA_WIDTH-1:0] b_edge [N];
   logic signed [PORT_WIDTH-1:0] pe_a   [N][N];
   logic signed [DATA_WIDTH-1:0] pe_b   [N][N];
   logic signed [PW2-1:0]        prod   [N][N];
   logic signed [DATA_WIDTH-1:0] mac    [N][N];

   logic signed [DATA_WIDTH:0]   s0;
   logic signed [DATA_WIDTH+1:0] s1;
   logic signed [DATA_WIDTH+2:0] s2;
   logic signed [DATA_WIDTH+3:0] s3;

   // Array edges and PE interconnect: a enters from the left, b from the top.
   always_comb begin
      a_edge = '{a0_in, a1_in, a2_in, a3_in, a4_in};
      b_edge = '{DATA_WIDTH'(b0_in), DATA_WIDTH'(b1_in), DATA_WIDTH'(b2_in),
                 DATA_WIDTH'(b3_in), DATA_WIDTH'(b4_in)};
      for (int unsigned i = 0; i < N; i++) begin
         pe_a[i][0] = a_edge[i];
         for (int unsigned j = 1; j < N; j++)
            pe_a[i][j] = a_q[i][j-1][PE_LATENCY-1];
      end
      for (int unsigned j = 0; j < N; j++) begin
         pe_b[0][j] = b_edge[j];
         for (int unsigned i = 1; i < N; i++)
            pe_b[i][j] = b_q[i-1][j][PE_LATENCY-1];
      end
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            prod[i][j] = PW2'(pe_a[i][j]) * PW2'(w_q[i][j]);
            mac[i][j]  = pe_b[i][j] + DATA_WIDTH'(prod[i][j]);
         end
      end
   end

   // Column adder chain; each stage grows by one bit so nothing wraps.
   always_comb begin
      s0 = (DATA_WIDTH+1)'(y0_out) + (DATA_WIDTH+1)'(y1_out);
      s1 = (DATA_WIDTH+2)'(s0)     + (DATA_WIDTH+2)'(y2_out);
      s2 = (DATA_WIDTH+3)'(s1)     + (DATA_WIDTH+3)'(y3_out);
      s3 = (DATA_WIDTH+4)'(s2)     + (DATA_WIDTH+4)'(y4_out);
   end

   // Locations 25..31 never match any PE index, so those writes are dropped.
   // A weight-load cycle zeroes every a/b stage so stale products flush out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q     <= '{default: '0};
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         acc_out <= '0;
      end else begin
         acc_out <= s3;
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               if (WorI && (weight_location == 5'(i*N + j)))
                  w_q[i][j] <= weight_in;
               a_q[i][j][0] <= WorI ? '0 : pe_a[i][j];
               b_q[i][j][0] <= WorI ? '0 : mac[i][j];
               for (int unsigned k = 1; k < PE_LATENCY; k++) begin
                  a_q[i][j][k] <= WorI ? '0 : a_q[i][j][k-1];
                  b_q[i][j][k] <= WorI ? '0 : b_q[i][j][k-1];
               end
            end
         end
      end
   end

   localparam int T = PE_LATENCY - 1;

   assign y0_out = b_q[N-1][0][T];
   assign y1_out = b_q[N-1][1][T];
   assign y2_out = b_q[N-1][2][T];
   assign y3_out = b_q[N-1][3][T];
   assign y4_out = b_q[N-1][4][T];

   assign a00_out = a_q[0][0][T]; assign a01_out = a_q[0][1][T]; assign a02_out = a_q[0][2][T]; assign a03_out = a_q[0][3][T]; assign a04_out = a_q[0][4][T];
   assign a10_out = a_q[1][0][T]; assign a11_out = a_q[1][1][T]; assign a12_out = a_q[1][2][T]; assign a13_out = a_q[1][3][T]; assign a14_out = a_q[1][4][T];
   assign a20_out = a_q[2][0][T]; assign a21_out = a_q[2][1][T]; assign a22_out = a_q[2][2][T]; assign a23_out = a_q[2][3][T]; assign a24_out = a_q[2][4][T];
   assign a30_out = a_q[3][0][T]; assign a31_out = a_q[3][1][T]; assign a32_out = a_q[3][2][T]; assign a33_out = a_q[3][3][T]; assign a34_out = a_q[3][4][T];
   assign a40_out = a_q[4][0][T]; assign a41_out = a_q[4][1][T]; assign a42_out = a_q[4][2][T]; assign a43_out = a_q[4][3][T]; assign a44_out = a_q[4][4][T];

   assign b00_out = b_q[0][0][T]; assign b01_out = b_q[0][1][T]; assign b02_out = b_q[0][2][T]; assign b03_out = b_q[0][3][T]; assign b04_out = b_q[0][4][T];
   assign b10_out = b_q[1][0][T]; assign b11_out = b_q[1][1][T]; assign b12_out = b_q[1][2][T]; assign b13_out = b_q[1][3][T]; assign b14_out = b_q[1][4][T];
   assign b20_out = b_q[2][0][T]; assign b21_out = b_q[2][1][T]; assign b22_out = b_q[2][2][T]; assign b23_out = b_q[2][3][T]; assign b24_out = b_q[2][4][T];
   assign b30_out = b_q[3][0][T]; assign b31_out = b_q[3][1][T]; assign b32_out = b_q[3][2][T]; assign b33_out = b_q[3][3][T]; assign b34_out = b_q[3][4][T];
   assign b40_out = b_q[4][0][T]; assign b41_out = b_q[4][1][T]; assign b42_out = b_q[4][2][T]; assign b43_out = b_q[4][3][T]; assign b44_out = b_q[4][4][T];

   assign w00_out = w_q[0][0]; assign w01_out = w_q[0][1]; assign w02_out = w_q[0][2]; assign w03_out = w_q[0][3]; assign w04_out = w_q[0][4];
   assign w10_out = w_q[1][0]; assign w11_out = w_q[1][1]; assign w12_out = w_q[1][2]; assign w13_out = w_q[1][3]; assign w14_out = w_q[1][4];
   assign w20_out = w_q[2][0]; assign w21_out = w_q[2][1]; assign w22_out = w_q[2][2]; assign w23_out = w_q[2][3]; assign w24_out = w_q[2][4];
   assign w30_out = w_q[3][0]; assign w31_out = w_q[3][1]; assign w32_out = w_q[3][2]; assign w33_out = w_q[3][3]; assign w34_out = w_q[3][4];
   assign w40_out = w_q[4][0]; assign w41_out = w_q[4][1]; assign w42_out = w_q[4][2]; assign w43_out = w_q[4][3]; assign w44_out = w_q[4][4];

endmodule

// File: tb/tb_pe_array.sv
// tb_pe_array: scoreboard bench for pe_array.
//   A driver issues stimulus each cycle and pushes the expected outputs, taken
//   from a dataflow formula over the input history, into a queue; a monitor
//   pops and compares on every falling edge.
module tb_pe_array;
   localparam int DW = 22;
   localparam int PW = 8;
   localparam int L  = 4;
   localparam int HN = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, wori;
   logic [4:0] wloc;
   logic signed [PW-1:0] win;
   logic signed [PW-1:0] a_i [5];
   logic signed [PW-1:0] b_i [5];
   logic signed [PW-1:0] a_o [5][5];
   logic signed [PW-1:0] w_o [5][5];
   logic signed [DW-1:0] b_o [5][5];
   logic signed [DW-1:0] y_o [5];
   logic signed [DW+3:0] acc_o;

   pe_array #(.DATA_WIDTH(DW), .PORT_WIDTH(PW), .N(5), .PE_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .WorI(wori),
      .a0_in(a_i[0]), .a1_in(a_i[1]), .a2_in(a_i[2]), .a3_in(a_i[3]), .a4_in(a_i[4]),
      .b0_in(b_i[0]), .b1_in(b_i[1]), .b2_in(b_i[2]), .b3_in(b_i[3]), .b4_in(b_i[4]),
      .weight_in(win), .weight_location(wloc),
      .y0_out(y_o[0]), .y1_out(y_o[1]), .y2_out(y_o[2]), .y3_out(y_o[3]), .y4_out(y_o[4]),
      .acc_out(acc_o),
      .a00_out(a_o[0][0]), .a01_out(a_o[0][1]), .a02_out(a_o[0][2]), .a03_out(a_o[0][3]), .a04_out(a_o[0][4]),
      .a10_out(a_o[1][0]), .a11_out(a_o[1][1]), .a12_out(a_o[1][2]), .a13_out(a_o[1][3]), .a14_out(a_o[1][4]),
      .a20_out(a_o[2][0]), .a21_out(a_o[2][1]), .a22_out(a_o[2][2]), .a23_out(a_o[2][3]), .a24_out(a_o[2][4]),
      .a30_out(a_o[3][0]), .a31_out(a_o[3][1]), .a32_out(a_o[3][2]), .a33_out(a_o[3][3]), .a34_out(a_o[3][4]),
      .a40_out(a_o[4][0]), .a41_out(a_o[4][1]), .a42_out(a_o[4][2]), .a43_out(a_o[4][3]), .a44_out(a_o[4][4]),
      .b00_out(b_o[0][0]), .b01_out(b_o[0][1]), .b02_out(b_o[0][2]), .b03_out(b_o[0][3]), .b04_out(b_o[0][4]),
      .b10_out(b_o[1][0]), .b11_out(b_o[1][1]), .b12_out(b_o[1][2]), .b13_out(b_o[1][3]), .b14_out(b_o[1][4]),
      .b20_out(b_o[2][0]), .b21_out(b_o[2][1]), .b22_out(b_o[2][2]), .b23_out(b_o[2][3]), .b24_out(b_o[2][4]),
      .b30_out(b_o[3][0]), .b31_out(b_o[3][1]), .b32_out(b_o[3][2]), .b33_out(b_o[3][3]), .b34_out(b_o[3][4]),
      .b40_out(b_o[4][0]), .b41_out(b_o[4][1]), .b42_out(b_o[4][2]), .b43_out(b_o[4][3]), .b44_out(b_o[4][4]),
      .w00_out(w_o[0][0]), .w01_out(w_o[0][1]), .w02_out(w_o[0][2]), .w03_out(w_o[0][3]), .w04_out(w_o[0][4]),
      .w10_out(w_o[1][0]), .w11_out(w_o[1][1]), .w12_out(w_o[1][2]), .w13_out(w_o[1][3]), .w14_out(w_o[1][4]),
      .w20_out(w_o[2][0]), .w21_out(w_o[2][1]), .w22_out(w_o[2][2]), .w23_out(w_o[2][3]), .w24_out(w_o[2][4]),
      .w30_out(w_o[3][0]), .w31_out(w_o[3][1]), .w32_out(w_o[3][2]), .w33_out(w_o[3][3]), .w34_out(w_o[3][4]),
      .w40_out(w_o[4][0]), .w41_out(w_o[4][1]), .w42_out(w_o[4][2]), .w43_out(w_o[4][3]), .w44_out(w_o[4][4])
   );

   int total = 0;
   int bad   = 0;
   int exp_q [$];

   // Reference model state: per-edge input history, current weights, last
   // edge at which the pipelines were cleared (reset or weight load).
   int ha [5][HN];
   int hb [5][HN];
   int ysum [HN];
   int wm [5][5];
   int flush_edge = -1;
   int e = 0;

   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic int tr(input int x, input int w);
      return (x <<< (32 - w)) >>> (32 - w);
   endfunction

   function automatic int ga(input int i, input int t);
      if (t < 0 || t <= flush_edge) return 0;
      return ha[i][t];
   endfunction

   function automatic int gb(input int j, input int t);
      if (t < 0 || t <= flush_edge) return 0;
      return hb[j][t];
   endfunction

   // Partial sum leaving PE(i,j) after edge m: seed bj entering 4i+3 edges
   // earlier, plus each row k<=i activation that met it at PE(k,j).
   function automatic int bexp(input int i, input int j, input int m);
      int s;
      s = gb(j, m - 3 - 4*i);
      for (int k = 0; k <= i; k++)
         s += ga(k, m - 3 - 4*i + 4*k - 4*j) * wm[k][j];
      return tr(s, DW);
   endfunction

   task automatic model_edge();
      int ys, y;
      if (!rst_n) begin
         flush_edge = e;
         for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) wm[i][j] = 0;
      end else if (wori) begin
         flush_edge = e;
         if (int'(wloc) < 25) wm[int'(wloc) / 5][int'(wloc) % 5] = int'(win);
      end
      for (int i = 0; i < 5; i++) begin
         ha[i][e] = int'(a_i[i]);
         hb[i][e] = int'(b_i[i]);
      end
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) exp_q.push_back(ga(i, e - 3 - 4*j));
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) exp_q.push_back(bexp(i, j, e));
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) exp_q.push_back(wm[i][j]);
      ys = 0;
      for (int j = 0; j < 5; j++) begin
         y = bexp(4, j, e);
         exp_q.push_back(y);
         ys += y;
      end
      ysum[e] = ys;
      exp_q.push_back((!rst_n || e == 0) ? 0 : tr(ysum[e-1], DW + 4));
      e++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() >= 81) begin
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++)
               chk($sformatf("a%0d%0d_out", i, j), int'(a_o[i][j]), exp_q.pop_front());
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++)
               chk($sformatf("b%0d%0d_out", i, j), int'(b_o[i][j]), exp_q.pop_front());
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++)
               chk($sformatf("w%0d%0d_out", i, j), int'(w_o[i][j]), exp_q.pop_front());
            for (int j = 0; j < 5; j++)
               chk($sformatf("y%0d_out", j), int'(y_o[j]), exp_q.pop_front());
            chk("acc_out", int'(acc_o), exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
      model_edge();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic load(input int loc, input int val);
      wori = 1'b1;
      wloc = 5'(loc);
      win  = PW'(val);
      step();
   endtask

   task automatic set_ab(input int av, input int bv);
      for (int i = 0; i < 5; i++) begin
         a_i[i] = PW'(av);
         b_i[i] = PW'(bv);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            chk($sformatf("%s_a%0d%0d", tag, i, j), int'(a_o[i][j]), 0);
            chk($sformatf("%s_b%0d%0d", tag, i, j), int'(b_o[i][j]), 0);
            chk($sformatf("%s_w%0d%0d", tag, i, j), int'(w_o[i][j]), 0);
         end
         chk($sformatf("%s_y%0d", tag, i), int'(y_o[i]), 0);
      end
      chk($sformatf("%s_acc", tag), int'(acc_o), 0);
   endtask

   task automatic check_steady(input string tag);
      @(negedge clk);
      #1;
      for (int j = 0; j < 5; j++) chk($sformatf("%s_y%0d", tag, j), int'(y_o[j]), 5);
      chk($sformatf("%s_acc", tag), int'(acc_o), 25);
   endtask

   initial begin
      rst_n = 1'b0; wori = 1'b0; wloc = '0; win = '0;
      set_ab(0, 0);
      #1;
      check_all_zero("reset");
      run(3);
      @(negedge clk);
      rst_n = 1'b1;

      // Weight load, with an out-of-range location at the end.
      for (int k = 0; k < 25; k++) load(k, k + 1);
      load(27, 99);
      wori = 1'b0;
      step();
      @(negedge clk);
      #1;
      chk("wload_w00", int'(w_o[0][0]), 1);
      chk("wload_w04", int'(w_o[0][4]), 5);
      chk("wload_w44", int'(w_o[4][4]), 25);

      // Single activation pulse through an all-ones array.
      for (int k = 0; k < 25; k++) load(k, 1);
      wori = 1'b0;
      a_i[0] = 8'sd2;
      step();
      a_i[0] = '0;
      run(30);

      // Seed pass-through.
      b_i[2] = -8'sd5;
      step();
      b_i[2] = '0;
      run(25);

      // Steady state, then asynchronous reset mid-run and recovery.
      set_ab(1, 0);
      run(40);
      check_steady("steady");
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      run(2);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 25; k++) load(k, 1);
      wori = 1'b0;
      run(40);
      check_steady("recover");

      // Extreme values in column 0.
      for (int r = 0; r < 5; r++) load(5*r, 127);
      wori = 1'b0;
      set_ab(-128, 0);
      run(40);
      @(negedge clk);
      #1;
      chk("extreme_y0", int'(y_o[0]), -81280);

      // Randomized weights, inputs, mid-run weight writes and one reset.
      for (int r = 0; r < 4; r++) begin
         wori = 1'b1;
         repeat (8) begin
            wloc = 5'($urandom_range(0, 31));
            win  = PW'($urandom);
            step();
         end
         wori = 1'b0;
         for (int c = 0; c < 70; c++) begin
            for (int i = 0; i < 5; i++) begin
               a_i[i] = PW'($urandom);
               b_i[i] = PW'($urandom);
            end
            wori = ($urandom_range(0, 29) == 0);
            wloc = 5'($urandom_range(0, 31));
            win  = PW'($urandom);
            if (r == 2 && c == 35) begin
               @(negedge clk);
               #1;
               rst_n = 1'b0;
               step();
               @(negedge clk);
               rst_n = 1'b1;
            end
            step();
         end
         wori = 1'b0;
      end

      set_ab(0, 0);
      run(2);
      @(negedge clk);
      #1;
      chk("queue_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
